// File: rtl/opendap_pkg.sv
// Shared definitions for the APB memory access port: register word addresses,
// address-increment modes, FSM state encodings and small decode helpers.
// Word addresses are ap_addr values ({APBANKSEL, A[3:2]}); byte offset = addr*4.
package opendap_pkg;

  // Register word addresses (byte offset / 4)
  localparam logic [5:0] AP_CSW  = 6'h00;  // 0x00
  localparam logic [5:0] AP_TAR  = 6'h01;  // 0x04
  localparam logic [5:0] AP_DRW  = 6'h03;  // 0x0C
  localparam logic [5:0] AP_BD0  = 6'h04;  // 0x10
  localparam logic [5:0] AP_BD1  = 6'h05;  // 0x14
  localparam logic [5:0] AP_BD2  = 6'h06;  // 0x18
  localparam logic [5:0] AP_BD3  = 6'h07;  // 0x1C
  localparam logic [5:0] AP_CFG  = 6'h3D;  // 0xF4
  localparam logic [5:0] AP_BASE = 6'h3E;  // 0xF8
  localparam logic [5:0] AP_IDR  = 6'h3F;  // 0xFC

  // CSW.AddrInc encodings; only single increment is acted upon
  localparam logic [1:0] AINC_OFF    = 2'b00;
  localparam logic [1:0] AINC_SINGLE = 2'b01;

  // CSW.Size is fixed at word
  localparam logic [2:0] CSW_SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } ap_state_t;

  // BD0..BD3 share the 16-byte block at 0x10
  function automatic logic is_bd(input logic [5:0] addr);
    return addr[5:2] == AP_BD0[5:2];
  endfunction

  // Accesses that turn into an APB transfer
  function automatic logic is_apb_reg(input logic [5:0] addr);
    return (addr == AP_DRW) || is_bd(addr);
  endfunction

endpackage

// File: rtl/opendap_mem_ap_apb.sv
// MEM-AP bridging DAP register accesses onto an APB master port.
// Latency: register accesses complete with ap_rdy held high; DRW/BDn take >= 3 cycles.
// Backpressure: ap_rdy low while an APB transfer is in flight; stretched by apb_pready.
module opendap_mem_ap_apb
  import opendap_pkg::*;
#(
  parameter logic [7:0]  APSEL = 8'h00,
  parameter logic [31:0] IDR   = 32'h04770002,
  parameter logic [31:0] BASE  = 32'h00000003
) (
  input  logic        swclk,
  input  logic        rst,
  input  logic [7:0]  ap_sel,
  input  logic [5:0]  ap_addr,
  input  logic [31:0] ap_wdata,
  input  logic        ap_wen,
  input  logic        ap_ren,
  input  logic        ap_abort,
  output logic [31:0] ap_rdata,
  output logic        ap_rdy,
  output logic        ap_err,
  output logic [31:0] apb_paddr,
  output logic        apb_psel,
  output logic        apb_penable,
  output logic        apb_pwrite,
  output logic [31:0] apb_pwdata,
  input  logic [31:0] apb_prdata,
  input  logic        apb_pready,
  input  logic        apb_pslverr
);

  ap_state_t   state, state_nxt;
  logic [1:0]  addr_inc;
  logic [31:0] tar;
  logic        xfer_drw;
  logic [31:0] reg_rdata;

  logic any_stb, sel_hit, accept, start, done, busy;

  assign any_stb = ap_wen | ap_ren;
  assign sel_hit = (ap_sel == APSEL);
  assign busy    = (state != ST_IDLE);
  // Strobes are only taken in IDLE; a strobe while busy is simply ignored
  assign accept  = any_stb && sel_hit && !busy && !ap_abort;
  assign start   = accept && is_apb_reg(ap_addr);
  // Abort wins over a coincident pready
  assign done    = (state == ST_ACCESS) && apb_pready && !ap_abort;

  // FSM state register; async reset drops psel/penable immediately
  always_ff @(posedge swclk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: IDLE -> SETUP -> ACCESS (wait pready) -> IDLE, abort from anywhere
  always_comb begin
    state_nxt = state;
    if (ap_abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) state_nxt = ST_SETUP;
        ST_SETUP:  state_nxt = ST_ACCESS;
        ST_ACCESS: if (apb_pready) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs decoded straight from the state register
  always_comb begin
    ap_rdy      = 1'b1;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    case (state)
      ST_SETUP: begin
        ap_rdy   = 1'b0;
        apb_psel = 1'b1;
      end
      ST_ACCESS: begin
        ap_rdy      = 1'b0;
        apb_psel    = 1'b1;
        apb_penable = 1'b1;
      end
      default: ;
    endcase
  end

  // Register read mux for accesses that complete without an APB transfer
  always_comb begin
    reg_rdata = 32'h0;
    case (ap_addr)
      AP_CSW:  reg_rdata = {24'h0, busy, 1'b1, addr_inc, 1'b0, CSW_SIZE_WORD};
      AP_TAR:  reg_rdata = tar;
      AP_BASE: reg_rdata = BASE;
      AP_IDR:  reg_rdata = IDR;
      default: reg_rdata = 32'h0;
    endcase
  end

  // CSW/TAR state and the post-transfer TAR auto-increment (wraps inside 1 KiB)
  always_ff @(posedge swclk or posedge rst) begin
    if (rst) begin
      addr_inc <= AINC_OFF;
      tar      <= 32'h0;
      xfer_drw <= 1'b0;
    end else begin
      if (accept && ap_wen) begin
        case (ap_addr)
          AP_CSW:  addr_inc <= ap_wdata[5:4];
          AP_TAR:  tar      <= {ap_wdata[31:2], 2'b00};
          default: ;
        endcase
      end
      if (start) xfer_drw <= (ap_addr == AP_DRW);
      if (done && !apb_pslverr && xfer_drw && (addr_inc == AINC_SINGLE))
        tar[9:2] <= tar[9:2] + 8'd1;
    end
  end

  // APB address/control/data latched at the strobe and held through SETUP/ACCESS
  always_ff @(posedge swclk or posedge rst) begin
    if (rst) begin
      apb_paddr  <= 32'h0;
      apb_pwrite <= 1'b0;
      apb_pwdata <= 32'h0;
    end else if (start) begin
      apb_paddr  <= (ap_addr == AP_DRW) ? tar : {tar[31:4], ap_addr[1:0], 2'b00};
      apb_pwrite <= ap_wen;
      apb_pwdata <= ap_wdata;
    end
  end

  // Read data and one-cycle error flag returned to the DP
  always_ff @(posedge swclk or posedge rst) begin
    if (rst) begin
      ap_rdata <= 32'h0;
      ap_err   <= 1'b0;
    end else begin
      ap_err <= done && apb_pslverr;
      if (done && !apb_pwrite)
        ap_rdata <= apb_prdata;
      else if (accept && ap_ren && !is_apb_reg(ap_addr))
        ap_rdata <= reg_rdata;
      else if (any_stb && !sel_hit && !ap_abort)
        ap_rdata <= 32'h0;
    end
  end

endmodule
